// File: rtl/mrr_loopback_push_initiator_pkg.sv
// Purpose : shared widths and FSM encodings for the loopback push initiator.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: default frame geometry, assembly/push state enums, ceil_div helper.
package mrr_loopback_push_initiator_pkg;

  // Default frame geometry.
  localparam int DEF_CHIP_ID_LEN          = 20;
  localparam int DEF_LOOPBACK_MESSAGE_LEN = 64;
  localparam int DEF_AXIS_WIDTH           = 32;
  localparam int DEF_CNT_LEN              = 16;

  // Assembly FSM: chip-ID beat, message beats, discard of an over-long frame.
  typedef enum logic [1:0] {
    A_CHIPID  = 2'd0,
    A_MSG     = 2'd1,
    A_DISCARD = 2'd2
  } asm_state_e;

  // Push FSM: four-phase request/acknowledge toward the loopback queue.
  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_REQ     = 2'd1,
    P_RELEASE = 2'd2
  } push_state_e;

  // Number of stream beats needed to carry a field of width a.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mrr_loopback_frame_assembler.sv
// Purpose : turns host stream beats into {chip ID, message} frames; drops malformed frames.
// Latency : frame offered on frm_vld_o in the same cycle its last beat transfers.
// Backpr. : s_axis_tready_o drops only while a complete frame is parked here and frm_rdy_i=0.
// Ports   : s_axis_* host stream in; frm_vld_o/frm_rdy_i/frm_chip_id_o/frm_message_o frame out;
//           drop_o pulses once per discarded frame.
module mrr_loopback_frame_assembler
  import mrr_loopback_push_initiator_pkg::*;
#(
  parameter int CHIP_ID_LEN          = DEF_CHIP_ID_LEN,
  parameter int LOOPBACK_MESSAGE_LEN = DEF_LOOPBACK_MESSAGE_LEN,
  parameter int AXIS_WIDTH           = DEF_AXIS_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AXIS_WIDTH-1:0]           s_axis_tdata_i,
  input  logic                            s_axis_tvalid_i,
  input  logic                            s_axis_tlast_i,
  output logic                            s_axis_tready_o,
  output logic                            frm_vld_o,
  input  logic                            frm_rdy_i,
  output logic [CHIP_ID_LEN-1:0]          frm_chip_id_o,
  output logic [LOOPBACK_MESSAGE_LEN-1:0] frm_message_o,
  output logic                            drop_o
);

  localparam int MSG_WORDS = ceil_div(LOOPBACK_MESSAGE_LEN, AXIS_WIDTH);
  localparam int MSG_BITS  = MSG_WORDS * AXIS_WIDTH;
  localparam int WCNT_W    = $clog2(MSG_WORDS) + 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(MSG_WORDS - 1);

  asm_state_e               state_q, state_d;
  logic [CHIP_ID_LEN-1:0]   chip_q,  chip_d;
  logic [MSG_BITS-1:0]      msg_q,   msg_d;
  logic [WCNT_W-1:0]        wcnt_q,  wcnt_d;
  // A complete frame is parked in chip_q/msg_q waiting for the holding stage.
  logic                     pend_q,  pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_CHIPID;
      chip_q  <= '0;
      msg_q   <= '0;
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chip_q  <= chip_d;
      msg_q   <= msg_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    logic                beat;
    logic [MSG_BITS-1:0] shifted;

    state_d         = state_q;
    chip_d          = chip_q;
    msg_d           = msg_q;
    wcnt_d          = wcnt_q;
    pend_d          = pend_q;
    drop_o          = 1'b0;
    frm_vld_o       = pend_q;
    frm_chip_id_o   = chip_q;
    frm_message_o   = msg_q[LOOPBACK_MESSAGE_LEN-1:0];
    // Stall the host only while a finished frame cannot move on.
    s_axis_tready_o = !(pend_q && !frm_rdy_i);

    beat    = s_axis_tvalid_i && s_axis_tready_o;
    // Most significant word arrives first, so each beat shifts in from the bottom.
    shifted = (msg_q << AXIS_WIDTH) | MSG_BITS'(s_axis_tdata_i);

    if (pend_q && frm_rdy_i) begin
      pend_d = 1'b0;
    end

    case (state_q)
      A_CHIPID: begin
        if (beat) begin
          chip_d = s_axis_tdata_i[CHIP_ID_LEN-1:0];
          wcnt_d = '0;
          if (s_axis_tlast_i) begin
            drop_o = 1'b1;
          end else begin
            state_d = A_MSG;
          end
        end
      end

      A_MSG: begin
        if (beat) begin
          msg_d  = shifted;
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (wcnt_q == LAST_WORD) begin
            if (s_axis_tlast_i) begin
              // Offer the frame straight from the incoming beat so an empty
              // holding stage takes it this cycle; otherwise park it.
              state_d       = A_CHIPID;
              frm_vld_o     = 1'b1;
              frm_message_o = shifted[LOOPBACK_MESSAGE_LEN-1:0];
              if (!frm_rdy_i) begin
                pend_d = 1'b1;
              end
            end else begin
              state_d = A_DISCARD;
            end
          end else if (s_axis_tlast_i) begin
            drop_o  = 1'b1;
            state_d = A_CHIPID;
          end
        end
      end

      A_DISCARD: begin
        if (beat && s_axis_tlast_i) begin
          drop_o  = 1'b1;
          state_d = A_CHIPID;
        end
      end

      default: begin
        state_d = A_CHIPID;
      end
    endcase
  end

endmodule

// File: rtl/mrr_loopback_push_initiator.sv
// Purpose : host-side producer for the loopback queue: assemble, hold one frame, four-phase push.
// Latency : last beat accepted -> push_request high in 2 cycles with the holding stage empty.
// Backpr. : unanswered pushes fill holding then assembly, after which s_axis_tready falls.
// Ports   : s_axis_* host stream; push_chip_id/push_message/push_request/push_ack queue side;
//           frames_pushed/frames_dropped saturating status counters.
module mrr_loopback_push_initiator
  import mrr_loopback_push_initiator_pkg::*;
#(
  parameter int CHIP_ID_LEN          = DEF_CHIP_ID_LEN,
  parameter int LOOPBACK_MESSAGE_LEN = DEF_LOOPBACK_MESSAGE_LEN,
  parameter int AXIS_WIDTH           = DEF_AXIS_WIDTH,
  parameter int CNT_LEN              = DEF_CNT_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AXIS_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [CHIP_ID_LEN-1:0]          push_chip_id,
  output logic [LOOPBACK_MESSAGE_LEN-1:0] push_message,
  output logic                            push_request,
  input  logic                            push_ack,
  output logic [CNT_LEN-1:0]              frames_pushed,
  output logic [CNT_LEN-1:0]              frames_dropped
);

  logic                            frm_vld;
  logic                            frm_rdy;
  logic [CHIP_ID_LEN-1:0]          frm_chip_id;
  logic [LOOPBACK_MESSAGE_LEN-1:0] frm_message;
  logic                            drop;

  mrr_loopback_frame_assembler #(
    .CHIP_ID_LEN          (CHIP_ID_LEN),
    .LOOPBACK_MESSAGE_LEN (LOOPBACK_MESSAGE_LEN),
    .AXIS_WIDTH           (AXIS_WIDTH)
  ) u_assembler (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata_i  (s_axis_tdata),
    .s_axis_tvalid_i (s_axis_tvalid),
    .s_axis_tlast_i  (s_axis_tlast),
    .s_axis_tready_o (s_axis_tready),
    .frm_vld_o       (frm_vld),
    .frm_rdy_i       (frm_rdy),
    .frm_chip_id_o   (frm_chip_id),
    .frm_message_o   (frm_message),
    .drop_o          (drop)
  );

  push_state_e                     pstate_q, pstate_d;
  logic                            hold_full_q, hold_full_d;
  logic [CHIP_ID_LEN-1:0]          hold_chip_q, hold_chip_d;
  logic [LOOPBACK_MESSAGE_LEN-1:0] hold_msg_q,  hold_msg_d;
  logic [CNT_LEN-1:0]              pushed_q,    pushed_d;
  logic [CNT_LEN-1:0]              dropped_q,   dropped_d;
  logic                            push_done;

  // The holding stage empties on the ack edge, so a frame finishing in the
  // same cycle can take its place without a bubble.
  assign push_done = (pstate_q == P_REQ) && push_ack;
  assign frm_rdy   = !hold_full_q || push_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q    <= P_IDLE;
      hold_full_q <= 1'b0;
      hold_chip_q <= '0;
      hold_msg_q  <= '0;
      pushed_q    <= '0;
      dropped_q   <= '0;
    end else begin
      pstate_q    <= pstate_d;
      hold_full_q <= hold_full_d;
      hold_chip_q <= hold_chip_d;
      hold_msg_q  <= hold_msg_d;
      pushed_q    <= pushed_d;
      dropped_q   <= dropped_d;
    end
  end

  // Push FSM next state.
  always_comb begin
    pstate_d = pstate_q;
    case (pstate_q)
      P_IDLE: begin
        // Never open a new handshake while the previous ack is still up.
        if (hold_full_q && !push_ack) begin
          pstate_d = P_REQ;
        end
      end
      P_REQ: begin
        if (push_ack) begin
          pstate_d = P_RELEASE;
        end
      end
      P_RELEASE: begin
        if (!push_ack) begin
          pstate_d = P_IDLE;
        end
      end
      default: begin
        pstate_d = P_IDLE;
      end
    endcase
  end

  // Holding stage and status counters.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_chip_d = hold_chip_q;
    hold_msg_d  = hold_msg_q;
    pushed_d    = pushed_q;
    dropped_d   = dropped_q;

    if (push_done) begin
      hold_full_d = 1'b0;
    end
    if (frm_vld && frm_rdy) begin
      hold_full_d = 1'b1;
      hold_chip_d = frm_chip_id;
      hold_msg_d  = frm_message;
    end

    if (push_done && (pushed_q != '1)) begin
      pushed_d = pushed_q + CNT_LEN'(1);
    end
    if (drop && (dropped_q != '1)) begin
      dropped_d = dropped_q + CNT_LEN'(1);
    end
  end

  // Holding registers stay untouched for the whole of P_REQ, which keeps
  // the queue-side data stable while the request is up.
  assign push_request   = (pstate_q == P_REQ);
  assign push_chip_id   = hold_chip_q;
  assign push_message   = hold_msg_q;
  assign frames_pushed  = pushed_q;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_mrr_loopback_push_initiator.sv
module tb_mrr_loopback_push_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [19:0] push_chip_id;
  logic [63:0] push_message;
  logic        push_request;
  logic        push_ack = 1'b0;
  logic [15:0] frames_pushed;
  logic [15:0] frames_dropped;

  mrr_loopback_push_initiator dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .push_chip_id   (push_chip_id),
    .push_message   (push_message),
    .push_request   (push_request),
    .push_ack       (push_ack),
    .frames_pushed  (frames_pushed),
    .frames_dropped (frames_dropped)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Queue-side model controls.
  int ack_delay = 3;
  int ack_hold  = 0;
  bit ack_en    = 1'b0;

  // Monitor state.
  logic [19:0] cap_chip[$];
  logic [63:0] cap_msg[$];
  int          cap_rise[$];
  int          ack_falls[$];
  int          fall_cyc = 0;
  int          n_push = 0;
  int          viol = 0;
  int          unstable = 0;
  int          stall_cnt = 0;
  int          beat_timeouts = 0;
  int          last_beat_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Four-phase queue responder: ack ack_delay cycles after request, release
  // ack ack_hold cycles after request falls.
  initial begin
    int rphase;
    int rcnt;
    rphase = 0;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        push_ack = 1'b0;
        rphase = 0;
        rcnt = 0;
      end else begin
        case (rphase)
          0: begin
            if (push_request && ack_en) begin
              rcnt++;
              if (rcnt > ack_delay) begin
                push_ack = 1'b1;
                rphase = 1;
              end
            end else begin
              rcnt = 0;
            end
          end
          1: begin
            if (!push_request) begin
              rcnt = 0;
              if (ack_hold == 0) begin
                push_ack = 1'b0;
                rphase = 0;
              end else begin
                rphase = 2;
              end
            end
          end
          default: begin
            rcnt++;
            if (rcnt >= ack_hold) begin
              push_ack = 1'b0;
              rphase = 0;
              rcnt = 0;
            end
          end
        endcase
      end
    end
  end

  // Push monitor, sampled on the falling edge.
  initial begin
    logic        prev_req;
    logic        prev_ack;
    logic [19:0] hchip;
    logic [63:0] hmsg;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    hchip = '0;
    hmsg = '0;
    forever begin
      @(negedge clk);
      if (push_request && !prev_req) begin
        cap_chip.push_back(push_chip_id);
        cap_msg.push_back(push_message);
        cap_rise.push_back(cyc);
        n_push++;
        if (prev_ack) viol++;
        hchip = push_chip_id;
        hmsg = push_message;
      end else if (push_request && prev_req) begin
        if (push_chip_id !== hchip || push_message !== hmsg) unstable++;
      end
      if (!push_request && prev_req) fall_cyc = cyc;
      if (!push_ack && prev_ack) ack_falls.push_back(cyc);
      prev_req = push_request;
      prev_ack = push_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; returns just after the edge on which it transferred.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    if (!s_axis_tready) stall_cnt++;
    while (!s_axis_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) beat_timeouts++;
    last_beat_cyc = cyc;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] chip, input logic [31:0] hi, input logic [31:0] lo);
    sync();
    send_beat(chip, 1'b0);
    send_beat(hi, 1'b0);
    send_beat(lo, 1'b1);
  endtask

  task automatic wait_pushes(input int target, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (n_push < target) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_caps();
    cap_chip.delete();
    cap_msg.delete();
    cap_rise.delete();
    ack_falls.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (push_request !== 1'b0 || s_axis_tready !== 1'b1 || frames_pushed !== 16'd0 ||
        frames_dropped !== 16'd0 || push_chip_id !== 20'd0 || push_message !== 64'd0) begin
      errors++;
      $display("FAIL reset_values: req=%b rdy=%b pushed=%0d dropped=%0d chip=%h msg=%h, want 0 1 0 0 0 0",
               push_request, s_axis_tready, frames_pushed, frames_dropped, push_chip_id, push_message);
    end
    sync();
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int base;
    clear_caps();
    ack_delay = 3; ack_hold = 0; ack_en = 1'b1;
    base = n_push;
    send_frame(32'h000ABCDE, 32'h11223344, 32'h55667788);
    wait_pushes(base + 1, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || cap_chip.size() != 1) begin
      errors++;
      $display("FAIL single_push_seen: pushes=%0d, want 1", cap_chip.size());
    end else begin
      checks++;
      if (cap_chip[0] !== 20'hABCDE) begin
        errors++;
        $display("FAIL single_chip: got %h want abcde", cap_chip[0]);
      end
      checks++;
      if (cap_msg[0] !== 64'h1122334455667788) begin
        errors++;
        $display("FAIL single_msg: got %h want 1122334455667788", cap_msg[0]);
      end
      checks++;
      if (cap_rise[0] - last_beat_cyc != 2) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles want 2", cap_rise[0] - last_beat_cyc);
      end
      checks++;
      if (fall_cyc - cap_rise[0] != 4) begin
        errors++;
        $display("FAIL single_req_fall: request high %0d cycles want 4", fall_cyc - cap_rise[0]);
      end
    end
    checks++;
    if (frames_pushed !== 16'd1 || frames_dropped !== 16'd0) begin
      errors++;
      $display("FAIL single_counters: pushed=%0d dropped=%0d want 1 0", frames_pushed, frames_dropped);
    end
  endtask

  task automatic test_short_frame();
    bit ok;
    int base;
    clear_caps();
    base = n_push;
    sync();
    send_beat(32'h00012345, 1'b0);
    send_beat(32'hAAAA5555, 1'b1);
    repeat (12) @(negedge clk);
    checks++;
    if (frames_dropped !== 16'd1 || n_push != base) begin
      errors++;
      $display("FAIL short_drop: dropped=%0d pushes=%0d want 1 0", frames_dropped, n_push - base);
    end
    // Upper chip-ID beat bits must be ignored.
    send_frame(32'hFFF12345, 32'hA5A5A5A5, 32'h0F0F0F0F);
    wait_pushes(base + 1, ok);
    repeat (8) @(negedge clk);
    checks++;
    if (!ok || cap_chip.size() != 1) begin
      errors++;
      $display("FAIL short_recover_seen: pushes=%0d want 1", cap_chip.size());
    end else if (cap_chip[0] !== 20'h12345 || cap_msg[0] !== 64'hA5A5A5A50F0F0F0F) begin
      errors++;
      $display("FAIL short_recover_data: chip=%h msg=%h want 12345 a5a5a5a50f0f0f0f", cap_chip[0], cap_msg[0]);
    end
    checks++;
    if (frames_pushed !== 16'd2) begin
      errors++;
      $display("FAIL short_pushed: got %0d want 2", frames_pushed);
    end
  endtask

  task automatic test_long_frame();
    int base;
    int stalls;
    base = n_push;
    stalls = stall_cnt;
    sync();
    for (int i = 0; i < 5; i++) send_beat(32'h10000000 + i, (i == 4));
    repeat (12) @(negedge clk);
    checks++;
    if (stall_cnt != stalls) begin
      errors++;
      $display("FAIL long_tready: %0d stalled beats want 0", stall_cnt - stalls);
    end
    checks++;
    if (frames_dropped !== 16'd2 || n_push != base) begin
      errors++;
      $display("FAIL long_drop: dropped=%0d pushes=%0d want 2 0", frames_dropped, n_push - base);
    end
    // Single-beat frame: tlast on the chip-ID beat.
    sync();
    send_beat(32'h00000077, 1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (frames_dropped !== 16'd3 || n_push != base) begin
      errors++;
      $display("FAIL onebeat_drop: dropped=%0d pushes=%0d want 3 0", frames_dropped, n_push - base);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_chip[3];
    logic [63:0] exp_msg[3];
    bit ok;
    int base;
    exp_chip[0] = 20'h00001; exp_msg[0] = 64'hDEADBEEF00000001;
    exp_chip[1] = 20'hFFFFF; exp_msg[1] = 64'h0123456789ABCDEF;
    exp_chip[2] = 20'h54321; exp_msg[2] = 64'hCAFEF00D12345678;
    clear_caps();
    base = n_push;
    ack_en = 1'b0; ack_delay = 2; ack_hold = 0;
    fork
      begin
        for (int f = 0; f < 3; f++)
          send_frame({12'h000, exp_chip[f]}, exp_msg[f][63:32], exp_msg[f][31:0]);
      end
      begin
        repeat (40) @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0 || push_request !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stalled: tready=%b req=%b want 0 1", s_axis_tready, push_request);
        end
        checks++;
        if (push_chip_id !== exp_chip[0] || push_message !== exp_msg[0] || frames_pushed !== 16'd2) begin
          errors++;
          $display("FAIL b2b_first_held: chip=%h msg=%h pushed=%0d want %h %h 2",
                   push_chip_id, push_message, frames_pushed, exp_chip[0], exp_msg[0]);
        end
        repeat (10) @(negedge clk);
        ack_en = 1'b1;
      end
    join
    wait_pushes(base + 3, ok);
    repeat (12) @(negedge clk);
    checks++;
    if (!ok || cap_chip.size() != 3 || beat_timeouts != 0) begin
      errors++;
      $display("FAIL b2b_count: pushes=%0d timeouts=%0d want 3 0", cap_chip.size(), beat_timeouts);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cap_chip[k] !== exp_chip[k] || cap_msg[k] !== exp_msg[k]) begin
          errors++;
          $display("FAIL b2b_order[%0d]: chip=%h msg=%h want %h %h",
                   k, cap_chip[k], cap_msg[k], exp_chip[k], exp_msg[k]);
        end
      end
    end
    checks++;
    if (frames_pushed !== 16'd5 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final: pushed=%0d tready=%b want 5 1", frames_pushed, s_axis_tready);
    end
  endtask

  task automatic test_four_phase();
    bit ok;
    int base;
    clear_caps();
    base = n_push;
    ack_en = 1'b1; ack_delay = 3; ack_hold = 10;
    send_frame(32'h00033333, 32'h00000000, 32'hFFFFFFFF);
    send_frame(32'h00044444, 32'h80000000, 32'h00000001);
    wait_pushes(base + 2, ok);
    repeat (30) @(negedge clk);
    checks++;
    if (!ok || cap_rise.size() != 2 || ack_falls.size() < 1) begin
      errors++;
      $display("FAIL four_phase_seen: pushes=%0d ack_falls=%0d want 2 >=1", cap_rise.size(), ack_falls.size());
    end else begin
      checks++;
      if (cap_rise[1] - ack_falls[0] != 2) begin
        errors++;
        $display("FAIL four_phase_gap: request rose %0d cycles after ack fell, want 2",
                 cap_rise[1] - ack_falls[0]);
      end
      checks++;
      if (cap_rise[1] - cap_rise[0] != 16) begin
        errors++;
        $display("FAIL four_phase_spacing: %0d cycles between requests want 16", cap_rise[1] - cap_rise[0]);
      end
      checks++;
      if (cap_chip[1] !== 20'h44444 || cap_msg[1] !== 64'h8000000000000001 ||
          cap_chip[0] !== 20'h33333 || cap_msg[0] !== 64'h00000000FFFFFFFF) begin
        errors++;
        $display("FAIL four_phase_data: %h/%h %h/%h want 33333/00000000ffffffff 44444/8000000000000001",
                 cap_chip[0], cap_msg[0], cap_chip[1], cap_msg[1]);
      end
    end
    checks++;
    if (viol != 0 || unstable != 0) begin
      errors++;
      $display("FAIL protocol: rise_with_ack=%0d unstable=%0d want 0 0", viol, unstable);
    end
    checks++;
    if (frames_pushed !== 16'd7) begin
      errors++;
      $display("FAIL four_phase_pushed: got %0d want 7", frames_pushed);
    end
    ack_hold = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    clear_caps();
    base = n_push;
    ack_en = 1'b0;
    send_frame(32'h00099999, 32'h12121212, 32'h34343434);
    wait_pushes(base + 1, ok);
    @(negedge clk);
    checks++;
    if (!ok || push_request !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: req=%b want 1", push_request);
    end
    sync();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (push_request !== 1'b0 || frames_pushed !== 16'd0 || frames_dropped !== 16'd0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: req=%b pushed=%0d dropped=%0d tready=%b want 0 0 0 1",
               push_request, frames_pushed, frames_dropped, s_axis_tready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (push_request !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_replay: req=%b want 0", push_request);
    end
    clear_caps();
    base = n_push;
    ack_en = 1'b1; ack_delay = 1;
    send_frame(32'h000C0FFE, 32'hFEEDFACE, 32'h0BADF00D);
    wait_pushes(base + 1, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || cap_chip.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_after_seen: pushes=%0d want 1", cap_chip.size());
    end else if (cap_chip[0] !== 20'hC0FFE || cap_msg[0] !== 64'hFEEDFACE0BADF00D) begin
      errors++;
      $display("FAIL rst_mid_after_data: chip=%h msg=%h want c0ffe feedface0badf00d", cap_chip[0], cap_msg[0]);
    end
    checks++;
    if (frames_pushed !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_after_pushed: got %0d want 1", frames_pushed);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_short_frame();
    test_long_frame();
    test_back_to_back();
    test_four_phase();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
